// File: rtl/branch_resolve_tracker.sv
// In-order retirement queue for predicted conditional branches. Branches resolve out of order
// and retire in program order, one per cycle, as training updates for the predictor tables.
module branch_resolve_tracker #(
  parameter int DEPTH    = 8,
  parameter int TAG_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_valid_i,
  output logic                alloc_ready_o,
  input  logic [31:0]         alloc_pc_i,
  input  logic                alloc_gshare_pred_i,
  input  logic                alloc_bimodal_pred_i,
  input  logic                alloc_final_pred_i,
  output logic [TAG_BITS-1:0] alloc_tag_o,
  input  logic                resolve_valid_i,
  input  logic [TAG_BITS-1:0] resolve_tag_i,
  input  logic                resolve_taken_i,
  input  logic                flush_valid_i,
  input  logic [TAG_BITS-1:0] flush_tag_i,
  output logic                update_valid_o,
  output logic [31:0]         update_pc_o,
  output logic                update_taken_o,
  output logic                update_gshare_correct_o,
  output logic                update_bimodal_correct_o,
  output logic                mispredict_o,
  output logic [TAG_BITS:0]   count_o
);
  localparam logic [TAG_BITS:0] DEPTH_C = (TAG_BITS+1)'(DEPTH);

  logic [DEPTH-1:0]    valid_q, valid_d, resolved_q, resolved_d;
  logic [DEPTH-1:0]    gshare_q, gshare_d, bimodal_q, bimodal_d;
  logic [DEPTH-1:0]    final_q, final_d, taken_q, taken_d;
  logic [31:0]         pc_q [DEPTH];
  logic [31:0]         pc_d [DEPTH];
  logic [TAG_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_BITS:0]   count_q, count_d;
  logic                upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
  logic                upd_gc_q, upd_gc_d, upd_bc_q, upd_bc_d, mis_q, mis_d;
  logic [31:0]         upd_pc_q, upd_pc_d;

  logic                retire, flush_hit, alloc_fire, res_ok;
  logic [TAG_BITS-1:0] flush_dist;
  logic [TAG_BITS:0]   survivors;
  logic [DEPTH-1:0]    kill;

  assign retire     = valid_q[head_q] && resolved_q[head_q];
  assign flush_hit  = flush_valid_i && valid_q[flush_tag_i];
  assign flush_dist = flush_tag_i - head_q;
  assign survivors  = {1'b0, flush_dist} + (TAG_BITS+1)'(1);

  // An entry is younger than the flush point when its age from head exceeds the flush tag's age.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_kill
      localparam logic [TAG_BITS-1:0] IDX = TAG_BITS'(gi);
      assign kill[gi] = flush_hit && ((IDX - head_q) > flush_dist);
    end
  endgenerate

  assign alloc_ready_o = (count_q < DEPTH_C) && !flush_valid_i;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign res_ok        = resolve_valid_i && valid_q[resolve_tag_i] &&
                         !resolved_q[resolve_tag_i] && !kill[resolve_tag_i];
  assign alloc_tag_o   = tail_q;

  always_comb begin
    valid_d     = valid_q & ~kill;
    resolved_d  = resolved_q;
    gshare_d    = gshare_q;
    bimodal_d   = bimodal_q;
    final_d     = final_q;
    taken_d     = taken_q;
    pc_d        = pc_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    upd_valid_d = retire;
    upd_pc_d    = upd_pc_q;
    upd_taken_d = upd_taken_q;
    upd_gc_d    = upd_gc_q;
    upd_bc_d    = upd_bc_q;
    mis_d       = 1'b0;

    if (res_ok) begin
      resolved_d[resolve_tag_i] = 1'b1;
      taken_d[resolve_tag_i]    = resolve_taken_i;
    end

    if (retire) begin
      valid_d[head_q]    = 1'b0;
      resolved_d[head_q] = 1'b0;
      head_d             = head_q + TAG_BITS'(1);
      upd_pc_d           = pc_q[head_q];
      upd_taken_d        = taken_q[head_q];
      upd_gc_d           = gshare_q[head_q] == taken_q[head_q];
      upd_bc_d           = bimodal_q[head_q] == taken_q[head_q];
      mis_d              = final_q[head_q] != taken_q[head_q];
    end

    if (alloc_fire) begin
      valid_d[tail_q]    = 1'b1;
      resolved_d[tail_q] = 1'b0;
      pc_d[tail_q]       = alloc_pc_i;
      gshare_d[tail_q]   = alloc_gshare_pred_i;
      bimodal_d[tail_q]  = alloc_bimodal_pred_i;
      final_d[tail_q]    = alloc_final_pred_i;
    end

    if (flush_hit) begin
      tail_d  = flush_tag_i + TAG_BITS'(1);
      count_d = survivors - {{TAG_BITS{1'b0}}, retire};
    end else begin
      tail_d  = tail_q + TAG_BITS'(alloc_fire);
      count_d = count_q + {{TAG_BITS{1'b0}}, alloc_fire} - {{TAG_BITS{1'b0}}, retire};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      resolved_q  <= '0;
      gshare_q    <= '0;
      bimodal_q   <= '0;
      final_q     <= '0;
      taken_q     <= '0;
      for (int i = 0; i < DEPTH; i++) pc_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
      upd_gc_q    <= 1'b0;
      upd_bc_q    <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      resolved_q  <= resolved_d;
      gshare_q    <= gshare_d;
      bimodal_q   <= bimodal_d;
      final_q     <= final_d;
      taken_q     <= taken_d;
      pc_q        <= pc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      upd_valid_q <= upd_valid_d;
      upd_pc_q    <= upd_pc_d;
      upd_taken_q <= upd_taken_d;
      upd_gc_q    <= upd_gc_d;
      upd_bc_q    <= upd_bc_d;
      mis_q       <= mis_d;
    end
  end

  assign update_valid_o           = upd_valid_q;
  assign update_pc_o              = upd_pc_q;
  assign update_taken_o           = upd_taken_q;
  assign update_gshare_correct_o  = upd_gc_q;
  assign update_bimodal_correct_o = upd_bc_q;
  assign mispredict_o             = mis_q;
  assign count_o                  = count_q;
endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Bench for branch_resolve_tracker: vector table, directed corner sequences and a random run,
// all cross-checked against a program-order queue model.
module tb_branch_resolve_tracker;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_valid = 1'b0;
  logic [31:0] alloc_pc = '0;
  logic        a_g = 1'b0, a_b = 1'b0, a_f = 1'b0;
  logic        res_v = 1'b0, res_tk = 1'b0;
  logic [2:0]  res_tag = '0;
  logic        fl_v = 1'b0;
  logic [2:0]  fl_tag = '0;
  logic        alloc_ready, upd_valid, upd_taken, upd_gc, upd_bc, mispredict;
  logic [2:0]  alloc_tag;
  logic [31:0] upd_pc;
  logic [3:0]  count;

  branch_resolve_tracker #(.DEPTH(8), .TAG_BITS(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_pc_i(alloc_pc),
    .alloc_gshare_pred_i(a_g), .alloc_bimodal_pred_i(a_b), .alloc_final_pred_i(a_f),
    .alloc_tag_o(alloc_tag),
    .resolve_valid_i(res_v), .resolve_tag_i(res_tag), .resolve_taken_i(res_tk),
    .flush_valid_i(fl_v), .flush_tag_i(fl_tag),
    .update_valid_o(upd_valid), .update_pc_o(upd_pc), .update_taken_o(upd_taken),
    .update_gshare_correct_o(upd_gc), .update_bimodal_correct_o(upd_bc),
    .mispredict_o(mispredict), .count_o(count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: in-flight branches kept oldest-first in a queue.
  typedef struct {
    logic [2:0]  tag;
    logic [31:0] pc;
    bit g, b, f, res, tk;
  } ent_t;
  ent_t        mq[$];
  logic [2:0]  m_tail;
  logic [31:0] m_pc;
  bit          m_tk, m_gc, m_bc, m_upd, m_mis;

  task automatic model_clear();
    mq.delete();
    m_tail = 3'd0;
    m_pc = '0; m_tk = 0; m_gc = 0; m_bc = 0; m_upd = 0; m_mis = 0;
  endtask

  task automatic cycle(input bit av, input logic [31:0] pc, input bit g, input bit b, input bit f,
                       input bit rv, input logic [2:0] rt, input bit rtk,
                       input bit fv, input logic [2:0] ft, output logic [2:0] tag_seen);
    bit   ready_exp, retire, found;
    ent_t head_e, ne;
    int   k;
    @(negedge clk);
    alloc_valid = av; alloc_pc = pc; a_g = g; a_b = b; a_f = f;
    res_v = rv; res_tag = rt; res_tk = rtk; fl_v = fv; fl_tag = ft;
    #1;
    ready_exp = (mq.size() < 8) && !fv;
    chk("alloc_ready", alloc_ready, ready_exp);
    chk("alloc_tag", alloc_tag, m_tail);
    tag_seen = alloc_tag;
    @(posedge clk);
    retire = (mq.size() > 0) && mq[0].res;
    if (retire) head_e = mq[0];
    if (fv) begin
      k = -1;
      foreach (mq[i]) if (mq[i].tag == ft) k = i;
      if (k >= 0) begin
        while (mq.size() > k + 1) void'(mq.pop_back());
        m_tail = ft + 3'd1;
      end
    end
    if (rv) begin
      found = 0;
      foreach (mq[i]) if (mq[i].tag == rt && !found) begin
        found = 1;
        if (!mq[i].res) begin mq[i].res = 1; mq[i].tk = rtk; end
      end
    end
    m_upd = retire;
    m_mis = 0;
    if (retire) begin
      void'(mq.pop_front());
      m_pc = head_e.pc; m_tk = head_e.tk;
      m_gc = (head_e.g == head_e.tk); m_bc = (head_e.b == head_e.tk);
      m_mis = (head_e.f != head_e.tk);
    end
    if (av && ready_exp) begin
      ne.tag = m_tail; ne.pc = pc; ne.g = g; ne.b = b; ne.f = f; ne.res = 0; ne.tk = 0;
      mq.push_back(ne);
      m_tail = m_tail + 3'd1;
    end
    #1;
    chk("update_valid", upd_valid, m_upd);
    chk("update_pc", upd_pc, m_pc);
    chk("update_taken", upd_taken, m_tk);
    chk("gshare_correct", upd_gc, m_gc);
    chk("bimodal_correct", upd_bc, m_bc);
    chk("mispredict", mispredict, m_mis);
    chk("count", count, mq.size());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alloc_valid = 0; res_v = 0; fl_v = 0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    chk("rst_count", count, 0);
    chk("rst_update_valid", upd_valid, 0);
    chk("rst_update_pc", upd_pc, 0);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit av; logic [31:0] pc; bit g, b, f;
    bit rv; logic [2:0] rt; bit rtk;
    logic [2:0] etag; bit eupd; logic [31:0] epc; bit etk, egc, ebc, emis; logic [3:0] ecnt;
  } vec_t;
  vec_t tbl[16];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] t;
    tbl[0]  = '{1, 32'h100, 1, 0, 0, 0, 3'd0, 0, 3'd0, 0, 32'h000, 0, 0, 0, 0, 4'd1};
    tbl[1]  = '{0, 32'h000, 0, 0, 0, 1, 3'd0, 1, 3'd1, 0, 32'h000, 0, 0, 0, 0, 4'd1};
    tbl[2]  = '{0, 32'h000, 0, 0, 0, 0, 3'd0, 0, 3'd1, 1, 32'h100, 1, 1, 0, 1, 4'd0};
    tbl[3]  = '{0, 32'h000, 0, 0, 0, 0, 3'd0, 0, 3'd1, 0, 32'h100, 1, 1, 0, 0, 4'd0};
    tbl[4]  = '{1, 32'h200, 0, 0, 1, 0, 3'd0, 0, 3'd1, 0, 32'h100, 1, 1, 0, 0, 4'd1};
    tbl[5]  = '{1, 32'h204, 1, 1, 1, 0, 3'd0, 0, 3'd2, 0, 32'h100, 1, 1, 0, 0, 4'd2};
    tbl[6]  = '{1, 32'h208, 0, 1, 0, 0, 3'd0, 0, 3'd3, 0, 32'h100, 1, 1, 0, 0, 4'd3};
    tbl[7]  = '{0, 32'h000, 0, 0, 0, 1, 3'd3, 0, 3'd4, 0, 32'h100, 1, 1, 0, 0, 4'd3};
    tbl[8]  = '{0, 32'h000, 0, 0, 0, 1, 3'd2, 1, 3'd4, 0, 32'h100, 1, 1, 0, 0, 4'd3};
    tbl[9]  = '{0, 32'h000, 0, 0, 0, 1, 3'd1, 1, 3'd4, 0, 32'h100, 1, 1, 0, 0, 4'd3};
    tbl[10] = '{0, 32'h000, 0, 0, 0, 0, 3'd0, 0, 3'd4, 1, 32'h200, 1, 0, 0, 0, 4'd2};
    tbl[11] = '{0, 32'h000, 0, 0, 0, 0, 3'd0, 0, 3'd4, 1, 32'h204, 1, 1, 1, 0, 4'd1};
    tbl[12] = '{0, 32'h000, 0, 0, 0, 0, 3'd0, 0, 3'd4, 1, 32'h208, 0, 1, 0, 0, 4'd0};
    tbl[13] = '{0, 32'h000, 0, 0, 0, 0, 3'd0, 0, 3'd4, 0, 32'h208, 0, 1, 0, 0, 4'd0};
    tbl[14] = '{0, 32'h000, 0, 0, 0, 1, 3'd3, 1, 3'd4, 0, 32'h208, 0, 1, 0, 0, 4'd0};
    tbl[15] = '{0, 32'h000, 0, 0, 0, 1, 3'd0, 0, 3'd4, 0, 32'h208, 0, 1, 0, 0, 4'd0};

    model_clear();
    do_reset();

    // Vector table: single branch with mispredict, then out-of-order resolves of three branches.
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].av, tbl[i].pc, tbl[i].g, tbl[i].b, tbl[i].f,
            tbl[i].rv, tbl[i].rt, tbl[i].rtk, 0, 3'd0, t);
      chk("tbl_tag", t, tbl[i].etag);
      chk("tbl_upd_valid", upd_valid, tbl[i].eupd);
      chk("tbl_upd_pc", upd_pc, tbl[i].epc);
      chk("tbl_upd_taken", upd_taken, tbl[i].etk);
      chk("tbl_gshare_ok", upd_gc, tbl[i].egc);
      chk("tbl_bimodal_ok", upd_bc, tbl[i].ebc);
      chk("tbl_mispredict", mispredict, tbl[i].emis);
      chk("tbl_count", count, tbl[i].ecnt);
    end

    // Full queue: refuse allocs, retire, then reuse tag 0 after wrap.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 32'h1000 + 4 * i, 1, 1, 1, 0, 0, 0, 0, 0, t);
    chk("full_count", count, 8);
    chk("full_ready", alloc_ready, 0);
    cycle(1, 32'hdead, 0, 0, 0, 0, 0, 0, 0, 0, t);
    chk("full_refused_count", count, 8);
    cycle(1, 32'hdead, 0, 0, 0, 1, 3'd0, 1, 0, 0, t);
    cycle(1, 32'hdead, 0, 0, 0, 0, 0, 0, 0, 0, t);
    chk("full_retire_count", count, 7);
    chk("wrap_ready", alloc_ready, 1);
    chk("wrap_tag", alloc_tag, 0);
    cycle(1, 32'h2000, 0, 1, 0, 0, 0, 0, 0, 0, t);
    chk("wrap_refill_count", count, 8);

    // Flush to tag 2 while tag 4 resolves, then flush to a resolved head.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, 32'h3000 + 4 * i, 0, 1, 1, 0, 0, 0, 0, 0, t);
    cycle(0, 0, 0, 0, 0, 1, 3'd4, 1, 1, 3'd2, t);
    chk("flush_count", count, 3);
    chk("flush_next_tag", alloc_tag, 3);
    cycle(0, 0, 0, 0, 0, 1, 3'd4, 1, 0, 0, t);
    chk("flush_dropped_tag_count", count, 3);
    cycle(0, 0, 0, 0, 0, 1, 3'd0, 0, 0, 0, t);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 3'd0, t);
    chk("flush_head_upd", upd_valid, 1);
    chk("flush_head_count", count, 0);
    cycle(1, 32'h4000, 1, 0, 1, 1, 3'd0, 1, 0, 0, t);

    // Asynchronous reset with 4 pending (2 resolved) discards everything.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 32'h5000 + 4 * i, 1, 1, 0, 0, 0, 0, 0, 0, t);
    cycle(0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 0, t);
    cycle(0, 0, 0, 0, 0, 1, 3'd2, 1, 0, 0, t);
    cycle(0, 0, 0, 0, 0, 1, 3'd3, 0, 0, 0, t);
    chk("pre_rst_count", count, 4);
    @(negedge clk);
    alloc_valid = 0; res_v = 0; fl_v = 0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_update_valid", upd_valid, 0);
    chk("async_rst_update_pc", upd_pc, 0);
    chk("async_rst_update_taken", upd_taken, 0);
    chk("async_rst_alloc_tag", alloc_tag, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, t);

    // Random traffic against the queue model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 6, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 1) == 1, 3'($urandom), 1'($urandom),
            $urandom_range(0, 24) == 0, 3'($urandom), t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_resolve_tracker.md
# branch_resolve_tracker

Tracks in-flight conditional branches from prediction to resolution and produces the training stream for the predictor tables. At fetch/predict time it records the PC and the GShare, Bimodal and final (selector-chosen) directions under a tag. Execute units resolve tags out of order. The block retires entries in program order and drives one update per cycle, carrying taken/correct-per-predictor flags, to the GShare, Bimodal and tournament selector update ports.

## Interface
- DEPTH, 8, entries in the in-flight queue; power of two, minimum 2
- TAG_BITS, 3, log2(DEPTH)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- alloc_valid_i  in  1  record a new predicted branch
- alloc_ready_o  out  1  combinational: count < DEPTH && !flush_valid_i
- alloc_pc_i  in  32  branch PC
- alloc_gshare_pred_i  in  1  GShare direction
- alloc_bimodal_pred_i  in  1  Bimodal direction
- alloc_final_pred_i  in  1  direction actually used by fetch
- alloc_tag_o  out  TAG_BITS  tag assigned to a handshaked alloc (= tail pointer)
- resolve_valid_i  in  1  branch outcome available
- resolve_tag_i  in  TAG_BITS  tag being resolved
- resolve_taken_i  in  1  actual direction
- flush_valid_i  in  1  discard every entry younger than flush_tag_i
- flush_tag_i  in  TAG_BITS  youngest surviving tag
- update_valid_o  out  1  registered, one-cycle pulse per retired entry
- update_pc_o  out  32  registered PC of retired entry
- update_taken_o  out  1  registered actual direction
- update_gshare_correct_o  out  1  registered (gshare_pred == taken)
- update_bimodal_correct_o  out  1  registered (bimodal_pred == taken)
- mispredict_o  out  1  registered (final_pred != taken), qualified by update_valid_o
- count_o  out  TAG_BITS+1  registered occupancy

## Operation
- Storage per entry: valid, resolved, pc[31:0], gshare_pred, bimodal_pred, final_pred, taken. Pointers head and tail are TAG_BITS wide and wrap modulo DEPTH; count separates full from empty.
- Alloc: on alloc_valid_i && alloc_ready_o, write entry[tail] (valid=1, resolved=0), tail++, count++.
- Resolve: on resolve_valid_i, if entry[resolve_tag_i] is valid and unresolved, set resolved=1 and store taken. Resolves to an invalid or already-resolved tag are ignored with no state change.
- Retire: when entry[head] is valid and resolved (state before this edge), the block registers the update outputs from it, clears valid, head++, count--. At most one retire per cycle. In-order only: a resolved younger entry waits behind an unresolved head.
- Flush: if flush_tag_i names a valid entry, all entries from flush_tag_i+1 up to tail-1 (modulo) are invalidated, tail = flush_tag_i+1, and count is recomputed as the survivors (minus a same-cycle retire). A flush to an invalid tag is ignored.
- Precedence in a single cycle: flush is applied first. A resolve to a flushed tag is dropped. A resolve to a surviving tag is applied. Alloc is blocked because ready is low. Retire of the head proceeds normally, including when flush_tag_i == head, which leaves count = 0.
- Alloc and retire in the same cycle: count unchanged. When full, alloc is refused even if a retire happens that cycle.

## Timing
- Reset: head = tail = 0, all valid = 0, count_o = 0, update_valid_o = 0, all update_*_o and mispredict_o = 0. alloc_tag_o = 0 and alloc_ready_o = 1 (with flush_valid_i low).
- Reset mid-operation discards every entry immediately. No update pulses are emitted for discarded entries.
- Alloc to resolvable: an entry allocated at edge N may be resolved at edge N+1.
- Resolve to update: a resolve sampled at edge N for the head entry gives update_valid_o high in the cycle after edge N+1 (2-edge latency). For back-to-back resolved entries, updates are issued one per cycle.
- update_valid_o is high for exactly one cycle per retired entry. Data outputs hold their last value when update_valid_o is low.

## Test plan
- Reset, then alloc PC 0x100 (g=1, b=0, f=0) and resolve tag 0 taken=1 -> one update: pc 0x100, taken 1, gshare_correct 1, bimodal_correct 0, mispredict 1, two edges after the resolve.
- Alloc tags 0-2 and resolve in order 2, 1, 0 -> no update until tag 0 resolves, then three consecutive update pulses in order 0, 1, 2.
- Alloc 8 entries -> alloc_ready_o = 0 and count_o = 8. Alloc held high is refused. Resolve head -> ready returns after the retire, and tag 0 is reused after wrap.
- Alloc tags 0-5, then flush_tag = 2 in the same cycle as a resolve of tag 4 -> tag 4 is dropped, count_o = 3, and the next alloc gets tag 3.
- Resolve an unallocated tag, or resolve tag 0 twice -> no state change and no extra update pulse.
- Assert rst_n low with 4 entries pending and 2 resolved -> outputs go to zero asynchronously, and no update follows reset release.
